// File: rtl/mul8x8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul8x8_seq_ctrl
//   Unsigned 8x8 -> 16-bit multiplier built from a single 4x4 Wallace tree
//   core. Four nibble partial products are issued over four cycles and added
//   into a 16-bit accumulator at the correct weight. Valid/ready handshakes on
//   both sides let it sit inside a streaming datapath.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   operand pair on a/b is valid
//     in_ready   block accepts an operand pair this cycle (IDLE only)
//     a, b       8-bit unsigned operands
//     out_valid  product is valid (DONE)
//     out_ready  consumer accepts the product this cycle
//     product    16-bit unsigned result (the registered accumulator)
//     busy       high in any state other than IDLE
//
//   Parameter:
//     ZERO_SKIP  when 1, a zero operand skips the four partial-product steps
// ---------------------------------------------------------------------------
module mul8x8_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  step_reg, step_next;
  logic [15:0] acc_reg, acc_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  b_reg, b_next;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic        skip;

  // Step order: 0 = lo*lo, 1 = hi*lo, 2 = lo*hi, 3 = hi*hi.
  // step[0] selects the high nibble of A, step[1] the high nibble of B.
  assign nib_a = step_reg[0] ? a_reg[7:4] : a_reg[3:0];
  assign nib_b = step_reg[1] ? b_reg[7:4] : b_reg[3:0];

  wallace4x4 u_core (
    .x (nib_a),
    .y (nib_b),
    .p (pp)
  );

  // Weight of the partial product: 0, 4, 4, 8 bits.
  always_comb begin
    pp_shifted = {4'b0, pp, 4'b0};
    case (step_reg)
      2'd0:    pp_shifted = {8'b0, pp};
      2'd3:    pp_shifted = {pp, 8'b0};
      default: pp_shifted = {4'b0, pp, 4'b0};
    endcase
  end

  // A zero operand is detected on the latched copies during the first MUL
  // cycle, so a skipped operation still presents its result one edge after
  // acceptance (initiation interval of 3 with out_ready held high).
  assign skip = ZERO_SKIP && ((a_reg == 8'd0) || (b_reg == 8'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= 2'd0;
      acc_reg   <= 16'h0000;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      acc_reg   <= acc_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    acc_next   = acc_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    product    = acc_reg;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          acc_next   = 16'h0000;
          step_next  = 2'd0;
          state_next = MUL;
        end
      end

      MUL: begin
        if (skip) begin
          // Accumulator was cleared on acceptance and stays 0.
          state_next = DONE;
        end else begin
          acc_next  = acc_reg + pp_shifted;
          step_next = 2'(step_reg + 2'd1);
          if (step_reg == 2'd3) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// ---------------------------------------------------------------------------
// wallace4x4
//   Unsigned 4x4 -> 8-bit multiplier. Four AND-array rows are reduced by two
//   levels of 3:2 carry-save compressors, then one carry-propagate add.
//   The product never exceeds 225, so 8-bit intermediate vectors are exact.
//
//   Ports:
//     x, y  4-bit unsigned operands
//     p     8-bit unsigned product
// ---------------------------------------------------------------------------
module wallace4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [7:0] row [4];
  logic [7:0] s1, c1, s2, c2, c1_w;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      assign row[gi] = {4'b0, x & {4{y[gi]}}} << gi;
    end
  endgenerate

  // Level 1: rows 0..2
  assign s1 = row[0] ^ row[1] ^ row[2];
  assign c1 = (row[0] & row[1]) | (row[0] & row[2]) | (row[1] & row[2]);

  // Level 2: sum, weighted carry, row 3
  assign c1_w = c1 << 1;
  assign s2   = s1 ^ c1_w ^ row[3];
  assign c2   = (s1 & c1_w) | (s1 & row[3]) | (c1_w & row[3]);

  assign p = s2 + (c2 << 1);

endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul8x8_seq_ctrl
//   Two instances: dut index 0 with zero-skip enabled, index 1 without.
//   A transaction-level model tracks, per instance, whether it is idle, how
//   many cycles remain until the result shows, and the expected a*b. Outputs
//   are compared against it on every falling edge; directed tests add
//   hand-computed latencies and products.
// ---------------------------------------------------------------------------
module tb_mul8x8_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic [7:0]  a         [2];
  logic [7:0]  b         [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [15:0] product   [2];

  mul8x8_seq_ctrl #(.ZERO_SKIP(1'b1)) u_dut_zs (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .a         (a[0]),
    .b         (b[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .product   (product[0]),
    .busy      (busy[0])
  );

  mul8x8_seq_ctrl #(.ZERO_SKIP(1'b0)) u_dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .a         (a[1]),
    .b         (b[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .product   (product[1]),
    .busy      (busy[1])
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic checking = 1'b0;

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, i, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_idle   [2];
  logic        m_valid  [2];
  logic        m_pknown [2];
  int          m_cnt    [2];
  logic [15:0] m_prod   [2];
  logic [7:0]  m_a      [2];
  logic [7:0]  m_b      [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_idle[i]   <= 1'b1;
        m_valid[i]  <= 1'b0;
        m_pknown[i] <= 1'b1;
        m_cnt[i]    <= 0;
      end else if (m_idle[i]) begin
        if (in_valid[i]) begin
          m_idle[i]   <= 1'b0;
          m_pknown[i] <= 1'b0;
          m_cnt[i]    <= ((i == 0) && (a[i] == 8'd0 || b[i] == 8'd0)) ? 1 : 4;
          m_prod[i]   <= 16'(a[i]) * 16'(b[i]);
          m_a[i]      <= a[i];
          m_b[i]      <= b[i];
        end
      end else if (m_cnt[i] > 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) m_valid[i] <= 1'b1;
      end else if (m_valid[i] && out_ready[i]) begin
        m_valid[i] <= 1'b0;
        m_idle[i]  <= 1'b1;
        $display("txn dut%0d: %02h * %02h -> %04h (expected %04h)", i, m_a[i], m_b[i], product[i], m_prod[i]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 32'(in_ready[i]), 32'(m_idle[i]));
        chk("busy", i, 32'(busy[i]), 32'(!m_idle[i]));
        chk("out_valid", i, 32'(out_valid[i]), 32'(m_valid[i]));
        if (m_valid[i])  chk("product", i, 32'(product[i]), 32'(m_prod[i]));
        if (m_pknown[i]) chk("product_reset", i, 32'(product[i]), 32'h0);
      end
    end
  end

  // Output handshakes seen on instance 0 (counted on the falling edge before
  // the rising edge that completes them).
  int hs_cnt = 0;
  always @(negedge clk) begin
    if (out_valid[0] === 1'b1 && out_ready[0] === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  // ---------------- directed operation ----------------
  task automatic do_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                       input int hold, input bit junk, input int exp_lat,
                       input logic [15:0] exp_p, input string name);
    int w;
    int lat;
    @(negedge clk);
    in_valid[i]  = 1'b1;
    a[i]         = av;
    b[i]         = bv;
    out_ready[i] = (hold == 0);
    w = 0;
    while (!in_ready[i] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk({name, "_accept_timeout"}, i, 32'(w), 32'(0));
    @(negedge clk);  // acceptance edge has passed
    if (junk) begin
      in_valid[i] = 1'b1;
      a[i] = 8'h11;
      b[i] = 8'h11;
    end else begin
      in_valid[i] = 1'b0;
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
    lat = 0;
    while (!out_valid[i] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, i, 32'(lat), 32'(exp_lat));
    chk({name, "_product"}, i, 32'(product[i]), 32'(exp_p));
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(negedge clk);
        chk({name, "_hold_valid"}, i, 32'(out_valid[i]), 32'(1));
        chk({name, "_hold_product"}, i, 32'(product[i]), 32'(exp_p));
      end
      out_ready[i] = 1'b1;
      in_valid[i]  = 1'b0;
    end
    @(negedge clk);  // output handshake edge has passed
    chk({name, "_back_idle"}, i, 32'(in_ready[i]), 32'(1));
    chk({name, "_valid_drop"}, i, 32'(out_valid[i]), 32'(0));
    in_valid[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int hs_base;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      a[i]         = 8'h00;
      b[i]         = 8'h00;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    chk("reset_in_ready", 0, 32'(in_ready[0]), 32'(1));
    chk("reset_out_valid", 0, 32'(out_valid[0]), 32'(0));
    chk("reset_busy", 0, 32'(busy[0]), 32'(0));
    chk("reset_product", 0, 32'(product[0]), 32'h0);

    do_op(0, 8'h12, 8'h34, 0, 1'b0, 4, 16'h03A8, "basic");
    do_op(0, 8'hFF, 8'hFF, 0, 1'b0, 4, 16'hFE01, "max");
    do_op(0, 8'hA5, 8'h3C, 5, 1'b1, 4, 16'h26AC, "backpressure");
    do_op(0, 8'h00, 8'h7F, 0, 1'b0, 1, 16'h0000, "zskip");
    do_op(0, 8'h7F, 8'h00, 0, 1'b0, 1, 16'h0000, "zskip_b");
    do_op(1, 8'h00, 8'h7F, 0, 1'b0, 4, 16'h0000, "nozskip");
    do_op(1, 8'hA5, 8'h3C, 0, 1'b0, 4, 16'h26AC, "nozskip_mixed");

    // Reset during step 2 of an operation
    @(negedge clk);
    in_valid[0] = 1'b1;
    a[0] = 8'h55;
    b[0] = 8'hAA;
    @(negedge clk);  // E0: accepted
    in_valid[0] = 1'b0;
    @(negedge clk);  // after E1
    @(negedge clk);  // after E2: step 2 in progress
    rst_n = 1'b0;
    @(negedge clk);  // reset edge
    rst_n = 1'b1;
    chk("midreset_in_ready", 0, 32'(in_ready[0]), 32'(1));
    chk("midreset_busy", 0, 32'(busy[0]), 32'(0));
    chk("midreset_out_valid", 0, 32'(out_valid[0]), 32'(0));
    chk("midreset_product", 0, 32'(product[0]), 32'h0);
    do_op(0, 8'h03, 8'h05, 0, 1'b0, 4, 16'h000F, "post_reset");

    // Back-to-back stream, in_valid held high, out_ready high
    hs_base = hs_cnt;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    a[0] = 8'($urandom);
    b[0] = 8'($urandom);
    for (int n = 0; n < 256; n++) begin
      w = 0;
      while (!in_ready[0] && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk("stream_accept_timeout", 0, 32'(w), 32'(0));
      @(negedge clk);  // accepted
      a[0] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b[0] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (n == 255) in_valid[0] = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("stream_handshakes", 0, 32'(hs_cnt - hs_base), 32'(256));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
